// File: rtl/fifo_reg_mem.sv
// Register-array storage for level_fifo: one synchronous write port and one
// asynchronous read port, no reset, so it can be swapped for an SRAM wrapper.
module fifo_reg_mem #(
  parameter int ASIZE = 5,
  parameter int DSIZE = 32
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  logic [DSIZE-1:0] mem_q [2**ASIZE];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/level_fifo.sv
// Single-clock FIFO with fill level, almost-full/empty flags and sticky overflow.
// LEVEL_FIFO_OUTREG_EN adds a one-entry registered read stage (capacity DEPTH+1).
module level_fifo #(
  parameter int ASIZE  = 5,
  parameter int DSIZE  = 32,
  parameter int AF_RST = (2**ASIZE) - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_n,
  input  logic [ASIZE:0]   af_thr,
  input  logic [ASIZE:0]   ae_thr,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [ASIZE:0]   level,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             ovf
);

  localparam int DEPTH = 2**ASIZE;
  localparam int PW    = ASIZE + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             mem_empty, mem_full;
  logic [PW-1:0]    mem_level;
  logic             wr_fire, rd_fire, mem_pop;
  logic             mem_we;
  logic [DSIZE-1:0] mem_rdata;
  logic [PW-1:0]    af_eff;

  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign mem_full  = (wr_ptr_q[ASIZE-1:0] == rd_ptr_q[ASIZE-1:0])
                  && (wr_ptr_q[ASIZE] != rd_ptr_q[ASIZE]);
  assign mem_level = wr_ptr_q - rd_ptr_q;

  assign wr_ready = !mem_full;
  assign wr_fire  = wr_valid && wr_ready;
  assign mem_we   = wr_fire && rst_n && clear_n;

  fifo_reg_mem #(
    .ASIZE (ASIZE),
    .DSIZE (DSIZE)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[ASIZE-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[ASIZE-1:0]),
    .rdata_o (mem_rdata)
  );

`ifdef LEVEL_FIFO_OUTREG_EN
  logic             out_vld_q, out_vld_d;
  logic [DSIZE-1:0] out_data_q;
  logic [PW:0]      lvl_sum;

  assign rd_valid = out_vld_q;
  assign rd_data  = out_data_q;
  assign rd_fire  = out_vld_q && rd_ready;
  // Refill whenever the stage is empty or being drained this cycle.
  assign mem_pop  = !mem_empty && (!out_vld_q || rd_fire);

  always_comb begin
    out_vld_d = out_vld_q;
    if (mem_pop)      out_vld_d = 1'b1;
    else if (rd_fire) out_vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !clear_n) out_vld_q <= 1'b0;
    else                    out_vld_q <= out_vld_d;
  end

  always_ff @(posedge clk) begin
    if (mem_pop) out_data_q <= mem_rdata;
  end

  assign lvl_sum = {1'b0, mem_level} + {{PW{1'b0}}, out_vld_q};
  assign level   = (lvl_sum > (PW+1)'(DEPTH)) ? PW'(DEPTH)
                                              : lvl_sum[PW-1:0];
`else
  assign rd_valid = !mem_empty;
  assign rd_data  = mem_rdata;
  assign rd_fire  = rd_valid && rd_ready;
  assign mem_pop  = rd_fire;
  assign level    = mem_level;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q | (wr_valid & ~wr_ready);
    if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
    if (mem_pop) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !clear_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign af_eff       = (af_thr == '0) ? PW'(AF_RST) : af_thr;
  assign almost_full  = (level >= af_eff);
  assign almost_empty = (level <= ae_thr);
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_level_fifo.sv
// Bench for level_fifo (ASIZE=3, DSIZE=8): vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_level_fifo;

  logic       clk;
  logic       rst_n, clear_n;
  logic [3:0] af_thr, ae_thr;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, rd_ready;
  logic [3:0] level;
  logic       almost_full, almost_empty, ovf;

  level_fifo #(.ASIZE(3), .DSIZE(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_n      (clear_n),
    .af_thr       (af_thr),
    .ae_thr       (ae_thr),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_ok = 0;
`ifdef LEVEL_FIFO_OUTREG_EN
  bit         use_model = 0;
`else
  bit         use_model = 1;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int n, eff;
    if (!(use_model && m_ok)) return;
    n   = mq.size();
    eff = (af_thr == 0) ? 6 : int'(af_thr);
    chk("m_level", level, n);
    chk("m_wr_ready", wr_ready, n < 8);
    chk("m_rd_valid", rd_valid, n > 0);
    chk("m_ovf", ovf, m_ovf);
    chk("m_af", almost_full, n >= eff);
    chk("m_ae", almost_empty, n <= int'(ae_thr));
    if (n > 0) chk("m_rd_data", rd_data, mq[0]);
  endtask

  task automatic model_update();
    int  n;
    bit  rd, wr;
    n  = mq.size();
    rd = (n > 0) && rd_ready;
    wr = wr_valid && (n < 8);
    if (!rst_n || !clear_n) begin
      mq.delete();
      m_ovf = 0;
      if (!rst_n) m_ok = 1;
    end else begin
      if (wr_valid && n == 8) m_ovf = 1;
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(wr_data);
    end
  endtask

  task automatic drive(input bit rs, input bit cl, input bit wv,
                       input logic [7:0] wd, input bit rr);
    @(negedge clk);
    rst_n = rs; clear_n = cl; wr_valid = wv; wr_data = wd; rd_ready = rr;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic cyc(input bit rs, input bit cl, input bit wv,
                     input logic [7:0] wd, input bit rr);
    drive(rs, cl, wv, wd, rr);
    tick();
  endtask

  typedef struct {
    bit rs, cl, wv; logic [7:0] wd; bit rr;
    bit chk_en; int lvl; bit wrdy, rvld, ov, af, ae; logic [7:0] rd;
  } vec_t;

`ifndef LEVEL_FIFO_OUTREG_EN
  task automatic run_default();
    vec_t tv[$];
    vec_t v;
    // Reset with write held, fill, overflow attempt, drain, clear.
    v = '{0,1,1,8'hAA,0, 0,0,1,0,0,0,1,8'h00}; tv.push_back(v);
    v = '{0,1,1,8'hAB,0, 1,0,1,0,0,0,1,8'h00}; tv.push_back(v);
    v = '{1,1,0,8'h00,0, 1,0,1,0,0,0,1,8'h00}; tv.push_back(v);
    for (int k = 0; k < 8; k++) begin
      v = '{1,1,1,8'(8'h10+k),0, 1,k,1,(k>0),0,(k>=6),(k<=2),8'h10};
      tv.push_back(v);
    end
    v = '{1,1,1,8'h99,0, 1,8,0,1,0,1,0,8'h10}; tv.push_back(v);
    for (int j = 0; j < 8; j++) begin
      v = '{1,1,0,8'h00,1, 1,8-j,(j>0),1,1,((8-j)>=6),((8-j)<=2),8'(8'h10+j)};
      tv.push_back(v);
    end
    v = '{1,1,0,8'h00,0, 1,0,1,0,1,0,1,8'h00}; tv.push_back(v);
    v = '{1,0,0,8'h00,0, 1,0,1,0,1,0,1,8'h00}; tv.push_back(v);
    v = '{1,1,0,8'h00,0, 1,0,1,0,0,0,1,8'h00}; tv.push_back(v);

    af_thr = 4'd6; ae_thr = 4'd2;
    foreach (tv[i]) begin
      drive(tv[i].rs, tv[i].cl, tv[i].wv, tv[i].wd, tv[i].rr);
      if (tv[i].chk_en) begin
        chk($sformatf("t%0d_level", i), level, tv[i].lvl);
        chk($sformatf("t%0d_wr_ready", i), wr_ready, tv[i].wrdy);
        chk($sformatf("t%0d_rd_valid", i), rd_valid, tv[i].rvld);
        chk($sformatf("t%0d_ovf", i), ovf, tv[i].ov);
        chk($sformatf("t%0d_af", i), almost_full, tv[i].af);
        chk($sformatf("t%0d_ae", i), almost_empty, tv[i].ae);
        if (tv[i].rvld) chk($sformatf("t%0d_rd_data", i), rd_data, tv[i].rd);
      end
      tick();
    end

    // Wrap: hold level 4 with simultaneous write and read.
    for (int k = 0; k < 4; k++) cyc(1, 1, 1, 8'(8'h20 + k), 0);
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 1, 8'(8'h24 + k), 1);
      chk("wrap_level", level, 4);
      chk("wrap_data", rd_data, 8'(8'h20 + k));
      tick();
    end
    drive(1, 1, 0, 8'h00, 0);
    chk("wrap_ovf", ovf, 0);
    tick();

    // Thresholds.
    cyc(1, 0, 0, 8'h00, 0);
    for (int k = 0; k < 2; k++) cyc(1, 1, 1, 8'(8'h40 + k), 0);
    drive(1, 1, 1, 8'h42, 0);
    chk("ae_at2", almost_empty, 1);
    tick();
    drive(1, 1, 0, 8'h00, 0);
    chk("ae_at3", almost_empty, 0);
    tick();
    cyc(1, 1, 0, 8'h00, 1);
    drive(1, 1, 0, 8'h00, 0);
    chk("ae_after_read", almost_empty, 1);
    tick();
    af_thr = 4'd0;
    for (int k = 0; k < 3; k++) cyc(1, 1, 1, 8'(8'h50 + k), 0);
    drive(1, 1, 1, 8'h53, 0);
    chk("af_rst_at5", almost_full, 0);
    tick();
    drive(1, 1, 0, 8'h00, 0);
    chk("af_rst_at6", almost_full, 1);
    tick();
    af_thr = 4'd15; ae_thr = 4'd9;
    cyc(1, 1, 1, 8'h54, 0);
    cyc(1, 1, 1, 8'h55, 0);
    drive(1, 1, 1, 8'h56, 0);
    chk("big_af_full", almost_full, 0);
    chk("big_ae_full", almost_empty, 1);
    chk("full_wr_ready", wr_ready, 0);
    tick();
    drive(1, 1, 1, 8'h57, 1);
    chk("full_rd_no_wr", wr_ready, 0);
    tick();
    af_thr = 4'd6; ae_thr = 4'd2;
    cyc(1, 1, 0, 8'h00, 1);
    cyc(1, 1, 0, 8'h00, 1);

    // Clear at level 5 concurrent with a write.
    drive(1, 0, 1, 8'h77, 0);
    chk("pre_clr_level", level, 5);
    chk("pre_clr_ovf", ovf, 1);
    tick();
    drive(1, 1, 0, 8'h00, 0);
    chk("clr_level", level, 0);
    chk("clr_rd_valid", rd_valid, 0);
    chk("clr_ovf", ovf, 0);
    tick();
    cyc(1, 1, 1, 8'h5A, 0);
    drive(1, 1, 0, 8'h00, 1);
    chk("post_clr_data", rd_data, 8'h5A);
    chk("post_clr_level", level, 1);
    tick();

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) af_thr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) ae_thr = 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 49) != 0,
          $urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 5);
    end
  endtask
`else
  task automatic run_outreg();
    af_thr = 4'd6; ae_thr = 4'd2;
    cyc(0, 1, 1, 8'hAA, 0);
    cyc(0, 1, 1, 8'hAB, 0);
    drive(1, 1, 1, 8'h42, 0);
    chk("or_rst_level", level, 0);
    chk("or_rst_rd_valid", rd_valid, 0);
    chk("or_rst_wr_ready", wr_ready, 1);
    tick();
    drive(1, 1, 0, 8'h00, 0);
    chk("or_lat1_valid", rd_valid, 0);
    tick();
    drive(1, 1, 0, 8'h00, 1);
    chk("or_lat2_valid", rd_valid, 1);
    chk("or_lat2_data", rd_data, 8'h42);
    tick();
    drive(1, 1, 0, 8'h00, 0);
    chk("or_empty_valid", rd_valid, 0);
    tick();
    for (int k = 0; k < 9; k++) begin
      drive(1, 1, 1, 8'(8'hA0 + k), 0);
      chk($sformatf("or_fill%0d_ready", k), wr_ready, 1);
      tick();
    end
    drive(1, 1, 0, 8'h00, 0);
    chk("or_full_ready", wr_ready, 0);
    chk("or_full_level", level, 8);
    chk("or_full_af", almost_full, 1);
    tick();
    for (int k = 0; k < 9; k++) begin
      drive(1, 1, 0, 8'h00, 1);
      chk($sformatf("or_rd%0d_valid", k), rd_valid, 1);
      chk($sformatf("or_rd%0d_data", k), rd_data, 8'(8'hA0 + k));
      tick();
    end
    drive(1, 1, 0, 8'h00, 0);
    chk("or_drained", rd_valid, 0);
    chk("or_drained_level", level, 0);
    tick();
  endtask
`endif

  initial begin
    rst_n = 0; clear_n = 1; wr_valid = 0; wr_data = '0; rd_ready = 0;
    af_thr = 4'd6; ae_thr = 4'd2;
`ifdef LEVEL_FIFO_OUTREG_EN
    run_outreg();
`else
    run_default();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
